// File: rtl/wisc_control_unit.sv
// WISC-15 main instruction decoder: registered control strobes and ALU command
// with a sticky halt state that only reset can clear.
module wisc_control_unit #(
    parameter int unsigned OPW = 4,
    parameter int unsigned ACW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    output logic [ACW-1:0] alu_cmd,
    output logic           alu_src,
    output logic           reg_wrt,
    output logic           mem_to_reg,
    output logic           mem_wrt,
    output logic           branch,
    output logic           call,
    output logic           ret,
    output logic           halt,
    output logic           set_over,
    output logic           set_zero,
    output logic           llb,
    output logic           lhb
);

    localparam logic [OPW-1:0] OpAdd    = 4'b0000;
    localparam logic [OPW-1:0] OpPaddsb = 4'b0001;
    localparam logic [OPW-1:0] OpSub    = 4'b0010;
    localparam logic [OPW-1:0] OpNand   = 4'b0011;
    localparam logic [OPW-1:0] OpXor    = 4'b0100;
    localparam logic [OPW-1:0] OpSll    = 4'b0101;
    localparam logic [OPW-1:0] OpSrl    = 4'b0110;
    localparam logic [OPW-1:0] OpSra    = 4'b0111;
    localparam logic [OPW-1:0] OpLw     = 4'b1000;
    localparam logic [OPW-1:0] OpSw     = 4'b1001;
    localparam logic [OPW-1:0] OpLhb    = 4'b1010;
    localparam logic [OPW-1:0] OpLlb    = 4'b1011;
    localparam logic [OPW-1:0] OpB      = 4'b1100;
    localparam logic [OPW-1:0] OpCall   = 4'b1101;
    localparam logic [OPW-1:0] OpRet    = 4'b1110;
    localparam logic [OPW-1:0] OpHlt    = 4'b1111;

    localparam logic [ACW-1:0] AluAdd    = 4'b0000;
    localparam logic [ACW-1:0] AluSub    = 4'b0001;
    localparam logic [ACW-1:0] AluPaddsb = 4'b0010;
    localparam logic [ACW-1:0] AluXor    = 4'b0100;
    localparam logic [ACW-1:0] AluNand   = 4'b1000;
    localparam logic [ACW-1:0] AluSll    = 4'b1100;
    localparam logic [ACW-1:0] AluSrl    = 4'b1110;
    localparam logic [ACW-1:0] AluSra    = 4'b1111;

    typedef enum logic [0:0] {
        StRun,
        StHalt
    } state_e;

    typedef struct packed {
        logic [ACW-1:0] alu_cmd;
        logic           alu_src;
        logic           reg_wrt;
        logic           mem_to_reg;
        logic           mem_wrt;
        logic           branch;
        logic           call;
        logic           ret;
        logic           set_over;
        logic           set_zero;
        logic           llb;
        logic           lhb;
    } ctrl_t;

    state_e state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;

    // Halted: ctrl_d stays all-zero and the state never leaves StHalt.
    always_comb begin
        state_d = state_q;
        ctrl_d  = '0;
        if (state_q == StRun) begin
            unique case (opcode)
                OpAdd: begin
                    ctrl_d.reg_wrt  = 1'b1;
                    ctrl_d.set_zero = 1'b1;
                    ctrl_d.set_over = 1'b1;
                    ctrl_d.alu_cmd  = AluAdd;
                end
                OpPaddsb: begin
                    ctrl_d.reg_wrt = 1'b1;
                    ctrl_d.alu_cmd = AluPaddsb;
                end
                OpSub: begin
                    ctrl_d.reg_wrt  = 1'b1;
                    ctrl_d.set_zero = 1'b1;
                    ctrl_d.set_over = 1'b1;
                    ctrl_d.alu_cmd  = AluSub;
                end
                OpNand: begin
                    ctrl_d.reg_wrt  = 1'b1;
                    ctrl_d.set_zero = 1'b1;
                    ctrl_d.alu_cmd  = AluNand;
                end
                OpXor: begin
                    ctrl_d.reg_wrt  = 1'b1;
                    ctrl_d.set_zero = 1'b1;
                    ctrl_d.alu_cmd  = AluXor;
                end
                OpSll: begin
                    ctrl_d.reg_wrt  = 1'b1;
                    ctrl_d.set_zero = 1'b1;
                    ctrl_d.alu_src  = 1'b1;
                    ctrl_d.alu_cmd  = AluSll;
                end
                OpSrl: begin
                    ctrl_d.reg_wrt  = 1'b1;
                    ctrl_d.set_zero = 1'b1;
                    ctrl_d.alu_src  = 1'b1;
                    ctrl_d.alu_cmd  = AluSrl;
                end
                OpSra: begin
                    ctrl_d.reg_wrt  = 1'b1;
                    ctrl_d.set_zero = 1'b1;
                    ctrl_d.alu_src  = 1'b1;
                    ctrl_d.alu_cmd  = AluSra;
                end
                OpLw: begin
                    ctrl_d.reg_wrt    = 1'b1;
                    ctrl_d.mem_to_reg = 1'b1;
                    ctrl_d.alu_src    = 1'b1;
                end
                OpSw: begin
                    ctrl_d.mem_wrt = 1'b1;
                    ctrl_d.alu_src = 1'b1;
                end
                OpLhb: begin
                    ctrl_d.reg_wrt = 1'b1;
                    ctrl_d.lhb     = 1'b1;
                end
                OpLlb: begin
                    ctrl_d.reg_wrt = 1'b1;
                    ctrl_d.llb     = 1'b1;
                end
                OpB: begin
                    ctrl_d.branch = 1'b1;
                end
                OpCall: begin
                    ctrl_d.reg_wrt = 1'b1;
                    ctrl_d.call    = 1'b1;
                end
                OpRet: begin
                    ctrl_d.ret = 1'b1;
                end
                OpHlt: begin
                    state_d = StHalt;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign alu_cmd    = ctrl_q.alu_cmd;
    assign alu_src    = ctrl_q.alu_src;
    assign reg_wrt    = ctrl_q.reg_wrt;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign mem_wrt    = ctrl_q.mem_wrt;
    assign branch     = ctrl_q.branch;
    assign call       = ctrl_q.call;
    assign ret        = ctrl_q.ret;
    assign halt       = (state_q == StHalt);
    assign set_over   = ctrl_q.set_over;
    assign set_zero   = ctrl_q.set_zero;
    assign llb        = ctrl_q.llb;
    assign lhb        = ctrl_q.lhb;

endmodule

// File: tb/tb_wisc_control_unit.sv
// Bench for wisc_control_unit: decode table sweep via a scoreboard queue, plus
// hand-written reset, latency and sticky-halt sequences.
module tb_wisc_control_unit;

    logic       clk;
    logic       rst;
    logic [3:0] opcode;
    logic [3:0] alu_cmd;
    logic       alu_src, reg_wrt, mem_to_reg, mem_wrt, branch, call, ret, halt;
    logic       set_over, set_zero, llb, lhb;

    wisc_control_unit #(
        .OPW(4),
        .ACW(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .alu_cmd   (alu_cmd),
        .alu_src   (alu_src),
        .reg_wrt   (reg_wrt),
        .mem_to_reg(mem_to_reg),
        .mem_wrt   (mem_wrt),
        .branch    (branch),
        .call      (call),
        .ret       (ret),
        .halt      (halt),
        .set_over  (set_over),
        .set_zero  (set_zero),
        .llb       (llb),
        .lhb       (lhb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {alu_cmd, src rw m2r mw | br call ret hlt | so sz llb lhb}
    logic [15:0] got;
    assign got = {alu_cmd, alu_src, reg_wrt, mem_to_reg, mem_wrt,
                  branch, call, ret, halt, set_over, set_zero, llb, lhb};

    typedef struct {
        logic [3:0]  op;
        string       name;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [15:0] exp;
    } sb_t;

    vec_t tab[16];
    sb_t  sbq[$];
    int   total = 0;
    int   bad = 0;

    localparam logic [15:0] Zero = 16'h0000;

    task automatic check(input string name, input logic [15:0] exp);
        logic [5:0] excl;
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, exp);
        end
        excl = {branch, call, ret, halt, llb, lhb};
        total++;
        if ($countones(excl) > 1 || (mem_wrt && reg_wrt)) begin
            bad++;
            $display("FAIL %s_excl: got=%h want=at most one of br/call/ret/hlt/llb/lhb, no mw+rw",
                     name, got);
        end
    endtask

    task automatic drive(input logic [3:0] op, input string name, input logic [15:0] exp);
        @(negedge clk);
        opcode = op;
        sbq.push_back('{name, exp});
    endtask

    task automatic collect();
        sb_t e;
        @(posedge clk);
        #1;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $display("FAIL sb_empty: got=%h want=pending entry", got);
        end else begin
            total--;
            e = sbq.pop_front();
            check(e.name, e.exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        tab[0]  = '{4'h0, "add",    {4'b0000, 12'b0100_0000_1100}};
        tab[1]  = '{4'h1, "paddsb", {4'b0010, 12'b0100_0000_0000}};
        tab[2]  = '{4'h2, "sub",    {4'b0001, 12'b0100_0000_1100}};
        tab[3]  = '{4'h3, "nand",   {4'b1000, 12'b0100_0000_0100}};
        tab[4]  = '{4'h4, "xor",    {4'b0100, 12'b0100_0000_0100}};
        tab[5]  = '{4'h5, "sll",    {4'b1100, 12'b1100_0000_0100}};
        tab[6]  = '{4'h6, "srl",    {4'b1110, 12'b1100_0000_0100}};
        tab[7]  = '{4'h7, "sra",    {4'b1111, 12'b1100_0000_0100}};
        tab[8]  = '{4'h8, "lw",     {4'b0000, 12'b1110_0000_0000}};
        tab[9]  = '{4'h9, "sw",     {4'b0000, 12'b1001_0000_0000}};
        tab[10] = '{4'hA, "lhb",    {4'b0000, 12'b0100_0000_0001}};
        tab[11] = '{4'hB, "llb",    {4'b0000, 12'b0100_0000_0010}};
        tab[12] = '{4'hC, "b",      {4'b0000, 12'b0000_1000_0000}};
        tab[13] = '{4'hD, "call",   {4'b0000, 12'b0100_0100_0000}};
        tab[14] = '{4'hE, "ret",    {4'b0000, 12'b0000_0010_0000}};
        tab[15] = '{4'hF, "hlt",    {4'b0000, 12'b0000_0001_0000}};

        rst = 1'b1;
        opcode = 4'h0;
        #3;
        check("reset_async", Zero);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", Zero);
        @(negedge clk);
        rst = 1'b0;

        // Sweep 0000..1110; first entry is the first edge after reset release.
        for (int i = 0; i < 15; i++) begin
            drive(tab[i].op, tab[i].name, tab[i].exp);
            collect();
        end

        repeat (20) begin
            idx = int'($urandom_range(0, 14));
            drive(tab[idx].op, {"rnd_", tab[idx].name}, tab[idx].exp);
            collect();
        end

        // Mid-cycle opcode change must not show until the next rising edge.
        drive(4'h0, "lat_add", tab[0].exp);
        collect();
        #3;
        opcode = 4'h9;
        #1;
        check("lat_hold", tab[0].exp);
        sbq.push_back('{"lat_sw", tab[9].exp});
        collect();

        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid", Zero);
        @(negedge clk);
        rst = 1'b0;
        sbq.push_back('{"rst_release_sw", tab[9].exp});
        collect();

        drive(4'hF, "hlt", tab[15].exp);
        collect();
        repeat (3) begin
            drive(4'h0, "halted_add", tab[15].exp);
            collect();
        end
        drive(4'hD, "halted_call", tab[15].exp);
        collect();
        drive(4'h9, "halted_sw", tab[15].exp);
        collect();

        #2;
        rst = 1'b1;
        #1;
        check("halt_rst", Zero);
        @(negedge clk);
        rst = 1'b0;
        drive(4'h0, "post_halt_add", tab[0].exp);
        collect();
        drive(4'hC, "post_halt_b", tab[12].exp);
        collect();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wisc_control_unit.md
Name: wisc_control_unit

Overview:
- Main instruction decoder for the WISC-15 16-bit processor.
- Takes the 4-bit opcode of the instruction in decode and produces the registered datapath control strobes and the 4-bit ALU command for the next stage.
- Holds a sticky halt state that freezes all control activity after HLT until reset.

Parameters:
- OPW, 4, opcode width (fixed; other values unsupported)
- ACW, 4, ALU command width (fixed)

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- opcode  input  4  instruction bits [15:12]
- alu_cmd  output  4  ALU operation select
- alu_src  output  1  1 = ALU B operand from immediate/offset, 0 = register
- reg_wrt  output  1  register-file write enable
- mem_to_reg  output  1  1 = write-back data from data memory
- mem_wrt  output  1  data-memory write enable
- branch  output  1  conditional branch
- call  output  1  call: write return address, jump
- ret  output  1  return: jump to register target
- halt  output  1  processor halted (sticky)
- set_over  output  1  update V flag
- set_zero  output  1  update Z flag
- llb  output  1  load-low-byte write-back select
- lhb  output  1  load-high-byte write-back select

Behaviour:
- All outputs are registered on the rising edge of clk; opcode sampled at edge N appears on the outputs after edge N (1-cycle latency).
- rst high (asynchronous): all outputs 0 immediately; halted state cleared.
- Decode table (listed signals = 1; all others = 0):
  - 0000 ADD: reg_wrt, set_zero, set_over; alu_cmd = 0000
  - 0001 PADDSB: reg_wrt; alu_cmd = 0010
  - 0010 SUB: reg_wrt, set_zero, set_over; alu_cmd = 0001
  - 0011 NAND: reg_wrt, set_zero; alu_cmd = 1000
  - 0100 XOR: reg_wrt, set_zero; alu_cmd = 0100
  - 0101 SLL: reg_wrt, set_zero, alu_src; alu_cmd = 1100
  - 0110 SRL: reg_wrt, set_zero, alu_src; alu_cmd = 1110
  - 0111 SRA: reg_wrt, set_zero, alu_src; alu_cmd = 1111
  - 1000 LW: reg_wrt, mem_to_reg, alu_src; alu_cmd = 0000
  - 1001 SW: mem_wrt, alu_src; alu_cmd = 0000
  - 1010 LHB: reg_wrt, lhb; alu_cmd = 0000
  - 1011 LLB: reg_wrt, llb; alu_cmd = 0000
  - 1100 B: branch; alu_cmd = 0000
  - 1101 CALL: reg_wrt, call; alu_cmd = 0000
  - 1110 RET: ret; alu_cmd = 0000
  - 1111 HLT: halt; alu_cmd = 0000
- Exclusivity: at most one of branch/call/ret/halt/llb/lhb is high in any cycle; mem_wrt and reg_wrt are never both high.
- Sticky halt:
  - Once halt registers 1, it stays 1 on every later edge regardless of opcode.
  - While halted, all other outputs are held at 0 (alu_cmd = 0000).
  - Only rst clears the halted state.
- Reset mid-operation: rst asserted at any time forces all-zero outputs asynchronously. After rst deasserts, the first rising edge registers the decode of the current opcode.
- Unknown/X opcode bits: no requirement; the decode covers all 16 codes fully, so there is no default path.

Test Plan:
- Reset: rst = 1 with opcode = 0000 -> all outputs 0 immediately. Release rst, clock once -> reg_wrt = 1, set_zero = 1, set_over = 1, alu_cmd = 0000.
- Sweep opcodes 0000..1110, one per clock, checking each at the following edge:
  - 0001 -> reg_wrt = 1, set_zero = 0, set_over = 0, alu_cmd = 0010
  - 0011 -> alu_cmd = 1000
  - 0110 -> alu_src = 1, alu_cmd = 1110
- Memory ops:
  - 1000 -> reg_wrt = 1, mem_to_reg = 1, alu_src = 1, mem_wrt = 0
  - 1001 -> mem_wrt = 1, alu_src = 1, reg_wrt = 0, flags 0
- Control flow:
  - 1100 -> only branch = 1
  - 1101 -> reg_wrt = 1, call = 1
  - 1110 -> only ret = 1
  - 1010 -> reg_wrt = 1, lhb = 1
  - 1011 -> reg_wrt = 1, llb = 1
- Halt: apply 1111, then 0000 for 3 clocks -> halt = 1 and all other outputs 0 throughout. Assert rst -> halt = 0 immediately.
- Latency: change opcode mid-cycle from 0000 to 1001 -> outputs unchanged until the next rising edge, then SW pattern.
